bus_arbiter: RTL

- Shares the processor's 16-bit internal bus between several requesters, e.g. the control unit, the ALU writeback and the memory interface.
- Each requester asks for one transfer: a source register code and a one-hot set of destination registers.
- The block runs round-robin arbitration and drives the 4-bit select code into the bus mux.
- It waits one settle cycle, then pulses the destination load enables and acknowledges the requester.

---
 rtl/bus_pkg.sv | 41 ++++
 rtl/bus_arbiter_rr.sv | 40 ++++
 rtl/bus_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the internal-bus arbiter: register source codes,
// destination load-enable bit positions and the transfer FSM states.
package bus_pkg;

  localparam logic [3:0] SRC_RA = 4'b0000;
  localparam logic [3:0] SRC_RB = 4'b0001;
  localparam logic [3:0] SRC_RC = 4'b0010;
  localparam logic [3:0] SRC_R1 = 4'b0011;
  localparam logic [3:0] SRC_R2 = 4'b0100;
  localparam logic [3:0] SRC_R3 = 4'b0101;
  localparam logic [3:0] SRC_DR = 4'b0110;
  localparam logic [3:0] SRC_AC = 4'b1001;
  localparam logic [3:0] SRC_PC = 4'b1010;

  // The mux parks on DR whenever nothing has been selected yet.
  localparam logic [3:0] BUS_SELECT_RST = SRC_DR;

  localparam int DST_RA = 0;
  localparam int DST_RB = 1;
  localparam int DST_RC = 2;
  localparam int DST_R1 = 3;
  localparam int DST_R2 = 4;
  localparam int DST_R3 = 5;
  localparam int DST_DR = 6;
  localparam int DST_AR = 7;
  localparam int DST_IR = 8;
  localparam int DST_AC = 9;
  localparam int DST_PC = 10;
  localparam int DST_TR = 11;

  typedef enum logic [1:0] {IDLE, SETTLE, LOAD, FAULT} state_t;

  function automatic logic is_legal_src(input logic [3:0] src);
    case (src)
      SRC_RA, SRC_RB, SRC_RC, SRC_R1, SRC_R2,
      SRC_R3, SRC_DR, SRC_AC, SRC_PC: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// Combinational round-robin picker: first unmasked request at or after ptr,
// wrapping around to the lower indices.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [NREQ-1:0] eligible;

  assign eligible = req & ~mask;

  // Two passes: indices from ptr upward first, then the wrapped lower ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_grant && eligible[i] && (i >= int'(ptr))) begin
        any_grant = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any_grant && eligible[i] && (i < int'(ptr))) begin
        any_grant = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Internal-bus arbiter: grants one requester at a time, drives the mux select,
// waits a settle cycle, then pulses the destination load enables and done.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DST_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*4-1:0]     req_src,
  input  logic [NREQ*DST_W-1:0] req_dst,
  input  logic                  dst_ready,
  output logic [3:0]            bus_select,
  output logic [DST_W-1:0]      load_en,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester holds req_valid with stable src/dst until it sees
  // its done bit; done is a single-cycle acknowledge and needs no reply.
  state_t           state, state_next;
  logic [PTR_W-1:0] ptr, winner, grant_idx;
  logic [DST_W-1:0] dst_q, grant_dst;
  logic [3:0]       grant_src;
  logic [NREQ-1:0]  grant, mask;
  logic             any_grant, arb_en, grant_legal;

  // Completing a transfer arbitrates again, but never back to the same winner.
  always_comb begin
    mask = '0;
    if (state != IDLE) mask[winner] = 1'b1;
  end

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .req       (req_valid),
    .mask      (mask),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    grant_src = '0;
    grant_dst = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_src = req_src[4*i +: 4];
        grant_dst = req_dst[DST_W*i +: DST_W];
      end
    end
  end

  assign grant_legal = is_legal_src(grant_src) && (grant_dst != '0);

  always_comb begin
    state_next = state;
    load_en    = '0;
    done       = '0;
    err        = 1'b0;
    arb_en     = 1'b0;
    case (state)
      IDLE:   arb_en = 1'b1;
      SETTLE: state_next = LOAD;
      LOAD: begin
        load_en = dst_q;
        if (dst_ready) begin
          done[winner] = 1'b1;
          arb_en       = 1'b1;
        end
      end
      FAULT: begin
        done[winner] = 1'b1;
        err          = 1'b1;
        arb_en       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (arb_en) begin
      if (!any_grant)       state_next = IDLE;
      else if (grant_legal) state_next = SETTLE;
      else                  state_next = FAULT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      winner     <= '0;
      dst_q      <= '0;
      bus_select <= BUS_SELECT_RST;
    end else begin
      state <= state_next;
      if (arb_en && any_grant) begin
        winner <= grant_idx;
        dst_q  <= grant_dst;
        ptr    <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        // An illegal request leaves the mux where it was.
        if (grant_legal) bus_select <= grant_src;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
